// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the five-stage pipeline run-control sequencer:
// state encoding, default sizes, strobe bundle and the HALT opcode used by ID.
package pipeline_ctrl_pkg;

  localparam int unsigned REG_W             = 5;
  localparam int unsigned STATE_W           = 3;
  localparam int unsigned DRAIN_CYCLES_DFLT = 3;
  localparam int unsigned CNT_W_DFLT        = 32;
  localparam int unsigned STALL_W_DFLT      = 16;
  localparam int unsigned OPCODE_W          = 6;

  // Opcode ID decodes into halt_instr.
  localparam logic [OPCODE_W-1:0] HALT_OPCODE = 6'h3F;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE   = 3'd0,
    ST_RUN    = 3'd1,
    ST_STEP   = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_HALTED = 3'd4
  } seq_state_e;

  typedef struct packed {
    logic pc_enable;
    logic if_id_enable;
    logic if_id_flush;
    logic id_ex_flush;
    logic ex_mem_enable;
    logic mem_wb_enable;
  } strobe_t;

  function automatic logic is_active(input seq_state_e s);
    return (s == ST_RUN) || (s == ST_STEP);
  endfunction

endpackage

// File: rtl/pipeline_sequencer_if.sv
// Command, hazard-input and strobe/status bundle between the pipeline and its sequencer.
interface pipeline_sequencer_if #(
  parameter int unsigned CNT_W   = pipeline_ctrl_pkg::CNT_W_DFLT,
  parameter int unsigned STALL_W = pipeline_ctrl_pkg::STALL_W_DFLT
);
  import pipeline_ctrl_pkg::*;

  logic               run_cmd;
  logic               step_cmd;
  logic               halt_cmd;
  logic               halt_instr;
  logic               id_ex_mem_read;
  logic [REG_W-1:0]   id_ex_rt;
  logic [REG_W-1:0]   if_id_rs;
  logic [REG_W-1:0]   if_id_rt;
  logic               branch_taken;

  logic               pc_enable;
  logic               if_id_enable;
  logic               if_id_flush;
  logic               id_ex_flush;
  logic               ex_mem_enable;
  logic               mem_wb_enable;
  logic [STATE_W-1:0] state;
  logic               halted;
  logic [CNT_W-1:0]   cycle_count;
  logic [STALL_W-1:0] stall_count;

  modport master (
    output run_cmd, step_cmd, halt_cmd, halt_instr, id_ex_mem_read,
           id_ex_rt, if_id_rs, if_id_rt, branch_taken,
    input  pc_enable, if_id_enable, if_id_flush, id_ex_flush,
           ex_mem_enable, mem_wb_enable, state, halted, cycle_count, stall_count
  );

  modport slave (
    input  run_cmd, step_cmd, halt_cmd, halt_instr, id_ex_mem_read,
           id_ex_rt, if_id_rs, if_id_rt, branch_taken,
    output pc_enable, if_id_enable, if_id_flush, id_ex_flush,
           ex_mem_enable, mem_wb_enable, state, halted, cycle_count, stall_count
  );

endinterface

// File: rtl/load_use_detect.sv
// Load-use hazard detector: a load in ID_EX whose destination feeds the instruction in IF_ID.
module load_use_detect
  import pipeline_ctrl_pkg::*;
(
  input  logic             id_ex_mem_read_i,
  input  logic [REG_W-1:0] id_ex_rt_i,
  input  logic [REG_W-1:0] if_id_rs_i,
  input  logic [REG_W-1:0] if_id_rt_i,
  output logic             stall_o
);

  // r0 is hardwired to zero, so a load into it never creates a dependency.
  assign stall_o = id_ex_mem_read_i
                 && (id_ex_rt_i != '0)
                 && ((id_ex_rt_i == if_id_rs_i) || (id_ex_rt_i == if_id_rt_i));

endmodule

// File: rtl/pipeline_sequencer.sv
// Run/step/drain/halt sequencer with load-use bubbles and branch squash for the 5-stage pipeline.
// Define STALL_COUNTER_EN to build the saturating load-use stall counter; otherwise stall_count reads 0.
module pipeline_sequencer
  import pipeline_ctrl_pkg::*;
#(
  parameter int unsigned DRAIN_CYCLES = DRAIN_CYCLES_DFLT,
  parameter int unsigned CNT_W        = CNT_W_DFLT,
  parameter int unsigned STALL_W      = STALL_W_DFLT
) (
  input  logic          clock,
  input  logic          reset,
  pipeline_sequencer_if.slave bus
);

  localparam int unsigned DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DRAIN_W-1:0] DRAIN_LOAD = DRAIN_W'(DRAIN_CYCLES - 1);

  seq_state_e         state_q, state_d;
  logic [DRAIN_W-1:0] drain_q, drain_d;
  logic [CNT_W-1:0]   cycle_q, cycle_d;
  strobe_t            strb;
  logic               stall;
  logic               halt_req;
  logic               active;
  logic               counting;

  load_use_detect u_load_use_detect (
    .id_ex_mem_read_i (bus.id_ex_mem_read),
    .id_ex_rt_i       (bus.id_ex_rt),
    .if_id_rs_i       (bus.if_id_rs),
    .if_id_rt_i       (bus.if_id_rt),
    .stall_o          (stall)
  );

  assign halt_req = bus.halt_instr || bus.halt_cmd;
  assign active   = is_active(state_q);
  assign counting = active || (state_q == ST_DRAIN);

  // Next state and same-cycle strobes.
  always_comb begin
    strb    = '0;
    state_d = state_q;
    drain_d = drain_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.run_cmd) begin
          state_d = ST_RUN;
        end else if (bus.step_cmd) begin
          state_d = ST_STEP;
        end else if (bus.halt_cmd) begin
          state_d = ST_DRAIN;
          drain_d = DRAIN_LOAD;
        end
      end
      ST_RUN, ST_STEP: begin
        strb.pc_enable     = 1'b1;
        strb.if_id_enable  = 1'b1;
        strb.ex_mem_enable = 1'b1;
        strb.mem_wb_enable = 1'b1;
        if (halt_req) begin
          // Freeze fetch and bubble ID_EX so the HALT itself never issues.
          strb.pc_enable    = 1'b0;
          strb.if_id_enable = 1'b0;
          strb.id_ex_flush  = 1'b1;
          state_d           = ST_DRAIN;
          drain_d           = DRAIN_LOAD;
        end else begin
          if (stall) begin
            strb.pc_enable    = 1'b0;
            strb.if_id_enable = 1'b0;
            strb.id_ex_flush  = 1'b1;
          end else if (bus.branch_taken) begin
            strb.if_id_flush = 1'b1;
          end
          if (state_q == ST_STEP) begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_DRAIN: begin
        strb.id_ex_flush   = 1'b1;
        strb.ex_mem_enable = 1'b1;
        strb.mem_wb_enable = 1'b1;
        if (drain_q == '0) begin
          state_d = ST_HALTED;
        end else begin
          drain_d = drain_q - DRAIN_W'(1);
        end
      end
      ST_HALTED: begin
        state_d = ST_HALTED;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign cycle_d = counting ? (cycle_q + CNT_W'(1)) : cycle_q;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      drain_q <= '0;
      cycle_q <= '0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
      cycle_q <= cycle_d;
    end
  end

`ifdef STALL_COUNTER_EN
  logic               stall_evt;
  logic [STALL_W-1:0] stall_q;

  // A halt in the same cycle outranks the stall, so it is not a bubble.
  assign stall_evt = active && stall && !halt_req;

  always_ff @(posedge clock) begin
    if (!reset) begin
      stall_q <= '0;
    end else if (stall_evt && (stall_q != '1)) begin
      stall_q <= stall_q + STALL_W'(1);
    end
  end

  assign bus.stall_count = stall_q;
`else
  assign bus.stall_count = '0;
`endif

  assign bus.pc_enable     = strb.pc_enable;
  assign bus.if_id_enable  = strb.if_id_enable;
  assign bus.if_id_flush   = strb.if_id_flush;
  assign bus.id_ex_flush   = strb.id_ex_flush;
  assign bus.ex_mem_enable = strb.ex_mem_enable;
  assign bus.mem_wb_enable = strb.mem_wb_enable;
  assign bus.state         = state_q;
  assign bus.halted        = (state_q == ST_HALTED);
  assign bus.cycle_count   = cycle_q;

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Directed vector bench for pipeline_sequencer: table of per-cycle stimulus and expectations plus a drain-length sequence.
module tb_pipeline_sequencer;

  localparam logic [5:0] S_OFF = 6'b000000;
  localparam logic [5:0] S_ACT = 6'b110011;
  localparam logic [5:0] S_STL = 6'b000111;
  localparam logic [5:0] S_BR  = 6'b111011;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   tests = 0;
  int   fails = 0;

  always #5 clock = ~clock;

  pipeline_sequencer_if #(.CNT_W(32), .STALL_W(16)) bus ();

  pipeline_sequencer #(.DRAIN_CYCLES(3), .CNT_W(32), .STALL_W(16)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic        rst_n;
    logic        run;
    logic        step;
    logic        halt;
    logic        hi;
    logic        mr;
    logic [4:0]  ex_rt;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic        br;
    bit          chk_s;
    logic [5:0]  s;
    logic        h;
    logic [2:0]  st;
    logic [31:0] cyc;
    logic [15:0] stl;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(input logic rst_n, run, step, halt, hi, mr,
                              input int ex_rt, rs, rt, input logic br, input bit chk,
                              input logic [5:0] s, input logic h, input int st, cyc, stl);
    vec_t v;
    v.rst_n = rst_n; v.run = run; v.step = step; v.halt = halt; v.hi = hi; v.mr = mr;
    v.ex_rt = 5'(ex_rt); v.rs = 5'(rs); v.rt = 5'(rt); v.br = br; v.chk_s = chk;
    v.s = s; v.h = h; v.st = 3'(st); v.cyc = 32'(cyc); v.stl = 16'(stl);
    return v;
  endfunction

  function automatic logic [15:0] exp_stall(input logic [15:0] v);
`ifdef STALL_COUNTER_EN
    return v;
`else
    return (v & 16'h0);
`endif
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s vec %0d: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    reset              = v.rst_n;
    bus.run_cmd        = v.run;
    bus.step_cmd       = v.step;
    bus.halt_cmd       = v.halt;
    bus.halt_instr     = v.hi;
    bus.id_ex_mem_read = v.mr;
    bus.id_ex_rt       = v.ex_rt;
    bus.if_id_rs       = v.rs;
    bus.if_id_rt       = v.rt;
    bus.branch_taken   = v.br;
  endtask

  task automatic apply(input vec_t v, input int idx);
    @(negedge clock);
    drive(v);
    #1;
    if (v.chk_s) begin
      chk("strobes", idx, 32'({bus.pc_enable, bus.if_id_enable, bus.if_id_flush,
                               bus.id_ex_flush, bus.ex_mem_enable, bus.mem_wb_enable}), 32'(v.s));
      chk("halted", idx, 32'(bus.halted), 32'(v.h));
    end
    @(posedge clock);
    #1;
    chk("state", idx, 32'(bus.state), 32'(v.st));
    chk("cycle_count", idx, bus.cycle_count, v.cyc);
    chk("stall_count", idx, 32'(bus.stall_count), 32'(exp_stall(v.stl)));
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    drive(mk(0,0,0,0,0,0, 0,0,0,0, 0, S_OFF,0, 0,0,0));

    // Reset, idle, then start free-running.
    vq.push_back(mk(0,0,0,0,0,0, 0,0,0,0, 0, S_OFF,0, 0,0,0));
    vq.push_back(mk(0,0,0,0,0,0, 0,0,0,0, 1, S_OFF,0, 0,0,0));
    vq.push_back(mk(1,0,0,0,0,0, 0,0,0,0, 1, S_OFF,0, 0,0,0));
    vq.push_back(mk(1,1,0,0,0,0, 0,0,0,0, 1, S_OFF,0, 1,0,0));
    for (int i = 1; i <= 10; i++)
      vq.push_back(mk(1,0,0,0,0,0, 0,0,0,0, 1, S_ACT,0, 1,i,0));
    // Load-use hazards, r0 exemption, branch vs stall priority.
    vq.push_back(mk(1,0,0,0,0,1, 5,5,0,0, 1, S_STL,0, 1,11,1));
    vq.push_back(mk(1,0,0,0,0,1, 0,0,0,0, 1, S_ACT,0, 1,12,1));
    vq.push_back(mk(1,0,0,0,0,1, 7,3,7,0, 1, S_STL,0, 1,13,2));
    vq.push_back(mk(1,0,0,0,0,0, 7,7,7,0, 1, S_ACT,0, 1,14,2));
    vq.push_back(mk(1,0,0,0,0,1, 9,9,0,1, 1, S_STL,0, 1,15,3));
    vq.push_back(mk(1,0,0,0,0,0, 0,0,0,1, 1, S_BR ,0, 1,16,3));
    vq.push_back(mk(1,1,1,0,0,0, 0,0,0,0, 1, S_ACT,0, 1,17,3));
    // HALT instruction outranks a simultaneous stall and branch; drain then halt.
    vq.push_back(mk(1,0,0,0,1,1, 5,5,0,1, 1, S_STL,0, 3,18,3));
    vq.push_back(mk(1,1,0,0,0,0, 0,0,0,0, 1, S_STL,0, 3,19,3));
    vq.push_back(mk(1,0,0,0,0,0, 0,0,0,0, 1, S_STL,0, 3,20,3));
    vq.push_back(mk(1,0,0,0,0,0, 0,0,0,0, 1, S_STL,0, 4,21,3));
    vq.push_back(mk(1,1,0,0,0,0, 0,0,0,0, 1, S_OFF,1, 4,21,3));
    vq.push_back(mk(1,0,1,0,0,0, 0,0,0,0, 1, S_OFF,1, 4,21,3));
    vq.push_back(mk(0,0,0,0,0,0, 0,0,0,0, 1, S_OFF,1, 0,0,0));
    // Single step, then run+step together, then reset mid-drain.
    vq.push_back(mk(1,0,0,0,0,0, 0,0,0,0, 1, S_OFF,0, 0,0,0));
    vq.push_back(mk(1,0,1,0,0,0, 0,0,0,0, 1, S_OFF,0, 2,0,0));
    vq.push_back(mk(1,0,0,0,0,0, 0,0,0,0, 1, S_ACT,0, 0,1,0));
    vq.push_back(mk(1,0,0,0,0,0, 0,0,0,0, 1, S_OFF,0, 0,1,0));
    vq.push_back(mk(1,1,1,0,0,0, 0,0,0,0, 1, S_OFF,0, 1,1,0));
    vq.push_back(mk(1,0,0,0,0,0, 0,0,0,0, 1, S_ACT,0, 1,2,0));
    vq.push_back(mk(1,0,0,1,0,0, 0,0,0,0, 1, S_STL,0, 3,3,0));
    vq.push_back(mk(0,0,0,0,0,0, 0,0,0,0, 1, S_STL,0, 0,0,0));
    // halt_cmd straight from IDLE drains for three cycles.
    vq.push_back(mk(1,0,0,1,0,0, 0,0,0,0, 1, S_OFF,0, 3,0,0));
    vq.push_back(mk(1,0,0,0,0,0, 0,0,0,0, 1, S_STL,0, 3,1,0));
    vq.push_back(mk(1,0,0,0,0,0, 0,0,0,0, 1, S_STL,0, 3,2,0));
    vq.push_back(mk(1,0,0,0,0,0, 0,0,0,0, 1, S_STL,0, 4,3,0));
    // Stall consumes a step; step beats halt_cmd in IDLE; HALT during a step.
    vq.push_back(mk(0,0,0,0,0,0, 0,0,0,0, 1, S_OFF,1, 0,0,0));
    vq.push_back(mk(1,0,1,0,0,0, 0,0,0,0, 1, S_OFF,0, 2,0,0));
    vq.push_back(mk(1,0,0,0,0,1, 4,4,0,0, 1, S_STL,0, 0,1,1));
    vq.push_back(mk(1,0,1,1,0,0, 0,0,0,0, 1, S_OFF,0, 2,1,1));
    vq.push_back(mk(1,0,0,0,1,0, 0,0,0,0, 1, S_STL,0, 3,2,1));
    vq.push_back(mk(1,0,0,0,0,0, 0,0,0,0, 1, S_STL,0, 3,3,1));
    vq.push_back(mk(1,0,0,0,0,0, 0,0,0,0, 1, S_STL,0, 3,4,1));
    vq.push_back(mk(1,0,0,0,0,0, 0,0,0,0, 1, S_STL,0, 4,5,1));

    for (int i = 0; i < vq.size(); i++) apply(vq[i], i);

    // Bounded wait: halt_cmd from RUN must drain for exactly three cycles.
    apply(mk(0,0,0,0,0,0, 0,0,0,0, 1, S_OFF,1, 0,0,0), 100);
    apply(mk(1,1,0,0,0,0, 0,0,0,0, 1, S_OFF,0, 1,0,0), 101);
    @(negedge clock);
    bus.run_cmd  = 1'b0;
    bus.halt_cmd = 1'b1;
    @(posedge clock);
    #1;
    bus.halt_cmd = 1'b0;
    n = 0;
    while (bus.state == 3'd3 && n < 20) begin
      chk("drain_pc_enable", 200 + n, 32'(bus.pc_enable), 32'd0);
      chk("drain_ex_mem_enable", 200 + n, 32'(bus.ex_mem_enable), 32'd1);
      @(posedge clock);
      #1;
      n++;
    end
    chk("drain_length", 300, 32'(n), 32'd3);
    chk("drain_end_state", 301, 32'(bus.state), 32'd4);
    chk("drain_end_halted", 302, 32'(bus.halted), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
